// File: rtl/fft_pkg.sv
// Shared definitions for the 4-point FFT/IFFT butterfly stages.
// Holds the default sample width, the stage FSM states, a complex
// sample type, rotation selectors and the common sat/wrap helper.
package fft_pkg;

  localparam int W_DEF = 16;

  // Rotation applied to the difference output of a butterfly
  localparam int ROT_NONE  = 0;
  localparam int ROT_NEG_J = 1;
  localparam int ROT_POS_J = 2;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    CALC   = 2'd1,
    UNLOAD = 2'd2
  } fft_state_e;

  typedef struct packed {
    logic signed [W_DEF-1:0] re;
    logic signed [W_DEF-1:0] im;
  } cplx_t;

  // Fit a full-precision value into w signed bits: clamp when sat is set,
  // otherwise two's-complement wrap (drop the bits above w).
  function automatic logic signed [31:0] fit_w(input logic signed [31:0] x,
                                               input int w,
                                               input logic sat);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic signed [31:0] r;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (sat) begin
      r = (x > hi) ? hi : ((x < lo) ? lo : x);
    end else begin
      r = (x <<< (32 - w)) >>> (32 - w);
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bfly2.sv
// Combinational radix-2 butterfly: sum = a + b, dif = rot(a - b).
// ROT selects no rotation, -j (forward) or +j (inverse) on the difference.
// Optional macro FFT1_SAT_EN: clamp results instead of wrapping.
module fft_bfly2
  import fft_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int ROT = ROT_NONE
)
(
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  output logic signed [W-1:0] sum_re,
  output logic signed [W-1:0] sum_im,
  output logic signed [W-1:0] dif_re,
  output logic signed [W-1:0] dif_im
);

`ifdef FFT1_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  logic signed [W:0] sum_re_w;
  logic signed [W:0] sum_im_w;
  logic signed [W:0] dif_re_w;
  logic signed [W:0] dif_im_w;

  // Full-precision W+1 sum and difference; rotation is a swap plus negation,
  // realised by choosing the subtraction order so no extra bit is needed.
  always_comb begin
    sum_re_w = {a_re[W-1], a_re} + {b_re[W-1], b_re};
    sum_im_w = {a_im[W-1], a_im} + {b_im[W-1], b_im};
    if (ROT == ROT_NEG_J) begin
      dif_re_w = {a_im[W-1], a_im} - {b_im[W-1], b_im};
      dif_im_w = {b_re[W-1], b_re} - {a_re[W-1], a_re};
    end else if (ROT == ROT_POS_J) begin
      dif_re_w = {b_im[W-1], b_im} - {a_im[W-1], a_im};
      dif_im_w = {a_re[W-1], a_re} - {b_re[W-1], b_re};
    end else begin
      dif_re_w = {a_re[W-1], a_re} - {b_re[W-1], b_re};
      dif_im_w = {a_im[W-1], a_im} - {b_im[W-1], b_im};
    end
  end

  assign sum_re = W'(fit_w(32'(sum_re_w), W, SAT));
  assign sum_im = W'(fit_w(32'(sum_im_w), W, SAT));
  assign dif_re = W'(fit_w(32'(dif_re_w), W, SAT));
  assign dif_im = W'(fit_w(32'(dif_im_w), W, SAT));

endmodule

// File: rtl/fft_1_stream.sv
// Forward 4-point FFT first stage: buffers four streamed complex samples,
// computes y0=x0+x2, y1=x1+x3, y2=x0-x2, y3=-j(x1-x3) in one cycle, and
// streams the four results out with index and last flag.
// Optional macro FFT1_SAT_EN (in fft_bfly2): saturate instead of wrap.
module fft_1_stream
  import fft_pkg::*;
#(
  parameter int W = W_DEF
)
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_re,
  output logic signed [W-1:0] out_im,
  output logic [1:0]          out_idx,
  output logic                out_last
);

  fft_state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] k_q, k_d;

  logic [3:0][W-1:0] x_re_q, x_re_d, x_im_q, x_im_d;
  logic [3:0][W-1:0] y_re_q, y_re_d, y_im_q, y_im_d;

  logic signed [W-1:0] y0_re, y0_im, y1_re, y1_im;
  logic signed [W-1:0] y2_re, y2_im, y3_re, y3_im;

  // Even pair x0/x2 gives y0 (sum) and y2 (plain difference)
  fft_bfly2 #(.W(W), .ROT(ROT_NONE)) u_bfly_even (
    .a_re   (x_re_q[0]),
    .a_im   (x_im_q[0]),
    .b_re   (x_re_q[2]),
    .b_im   (x_im_q[2]),
    .sum_re (y0_re),
    .sum_im (y0_im),
    .dif_re (y2_re),
    .dif_im (y2_im)
  );

  // Odd pair x1/x3 gives y1 (sum) and y3 (difference rotated by -j)
  fft_bfly2 #(.W(W), .ROT(ROT_NEG_J)) u_bfly_odd (
    .a_re   (x_re_q[1]),
    .a_im   (x_im_q[1]),
    .b_re   (x_re_q[3]),
    .b_im   (x_im_q[3]),
    .sum_re (y1_re),
    .sum_im (y1_im),
    .dif_re (y3_re),
    .dif_im (y3_im)
  );

  // Next-state, buffer updates and handshake outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    x_re_d    = x_re_q;
    x_im_d    = x_im_q;
    y_re_d    = y_re_q;
    y_im_d    = y_im_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_re_d[cnt_q] = in_re;
          x_im_d[cnt_q] = in_im;
          cnt_d         = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        y_re_d  = {y3_re, y2_re, y1_re, y0_re};
        y_im_d  = {y3_im, y2_im, y1_im, y0_im};
        k_d     = 2'd0;
        state_d = UNLOAD;
      end
      UNLOAD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (k_q == 2'd3) begin
            // k stays at 3 so the last result remains on the output bus
            cnt_d   = 2'd0;
            state_d = LOAD;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State, counters and sample/result buffers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      k_q     <= '0;
      x_re_q  <= '0;
      x_im_q  <= '0;
      y_re_q  <= '0;
      y_im_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      x_re_q  <= x_re_d;
      x_im_q  <= x_im_d;
      y_re_q  <= y_re_d;
      y_im_q  <= y_im_d;
    end
  end

  assign out_re   = y_re_q[k_q];
  assign out_im   = y_im_q[k_q];
  assign out_idx  = k_q;
  assign out_last = (state_q == UNLOAD) && (k_q == 2'd3);

endmodule
